// File: rtl/insn_loader.sv
// Streams a program into instruction memory while holding the core in reset.
// Define INSN_LOADER_CLEAR_EN to zero-fill the whole memory before each load.
module insn_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] load_addr;
  logic              accept;

  // in_ready is registered and high exactly while in LOAD.
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      load_addr  <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_hold  <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
      error      <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make mem_we/done single-cycle pulses; a
      // later assignment in the same block overrides them for this edge.
      mem_we <= 1'b0;
      done   <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            word_count <= '0;
            error      <= 1'b0;
            load_addr  <= '0;
            core_hold  <= 1'b1;
`ifdef INSN_LOADER_CLEAR_EN
            state      <= S_CLEAR;
            mem_we     <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`else
            state      <= S_LOAD;
            in_ready   <= 1'b1;
`endif
          end
        end

        // mem_addr doubles as the clear pointer; the write to LAST_ADDR is
        // on the bus during the final CLEAR cycle.
        S_CLEAR: begin
          if (mem_addr == LAST_ADDR) begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= mem_addr + 1'b1;
            mem_wdata <= '0;
          end
        end

        S_LOAD: begin
          if (accept) begin
            mem_we     <= 1'b1;
            mem_addr   <= load_addr;
            mem_wdata  <= in_data;
            load_addr  <= load_addr + 1'b1;
            word_count <= word_count + 1'b1;
            // Stopping at the top address prevents a wrap-around overwrite.
            if (in_last || (load_addr == LAST_ADDR)) begin
              state    <= S_FINISH;
              in_ready <= 1'b0;
              done     <= 1'b1;
              error    <= !in_last;
            end
          end
        end

        S_FINISH: begin
          state     <= S_IDLE;
          core_hold <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_loader.sv
// Self-checking bench for insn_loader: a transaction-level model predicts every
// output each cycle, plus directed sessions with hand-computed memory contents.
module tb_insn_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
`ifdef INSN_LOADER_CLEAR_EN
  localparam int CLR_W = DEPTH;
`else
  localparam int CLR_W = 0;
`endif

  logic              clk = 1'b0;
  logic              reset, start, in_valid, in_last;
  logic [31:0]       in_data;
  logic              in_ready, mem_we, core_hold, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;

  always #5 clk = ~clk;

  insn_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .word_count(word_count),
    .error     (error)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  // Instruction memory seen by the loader, with write bookkeeping.
  logic [31:0]       ram [DEPTH];
  logic              fill_req = 1'b0;
  int                n_writes = 0;
  int                addr0_writes = 0;
  int                done_seen = 0;
  logic [ADDR_W-1:0] last_waddr = '0;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 32'hFFFF_FFFF;
    end else if (mem_we === 1'b1) begin
      ram[mem_addr] <= mem_wdata;
      n_writes      <= n_writes + 1;
      last_waddr    <= mem_addr;
      if (mem_addr == '0) addr0_writes <= addr0_writes + 1;
    end
  end

  always @(posedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

  // Behavioural model: session phase plus "writes still to issue" counters.
  localparam int P_IDLE = 0, P_CLEAR = 1, P_LOAD = 2, P_FINISH = 3;
  int                phase = P_IDLE;
  int                clear_left = 0;
  int                ld_next = 0;
  bit                m_live = 1'b0;
  logic              e_ready = 0, e_we = 0, e_hold = 0, e_done = 0, e_err = 0;
  logic [ADDR_W:0]   e_count = '0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [31:0]       e_wdata = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        phase = P_IDLE; clear_left = 0; ld_next = 0; m_live = 1'b1;
        e_ready = 0; e_we = 0; e_hold = 0; e_done = 0; e_err = 0;
        e_count = '0; e_addr = '0; e_wdata = '0;
      end else begin
        e_we = 0;
        e_done = 0;
        case (phase)
          P_IDLE: if (start) begin
            e_count = '0; e_err = 0; e_hold = 1; ld_next = 0;
            if (CLR_W != 0) begin
              phase = P_CLEAR; e_we = 1; e_addr = '0; e_wdata = '0;
              clear_left = DEPTH - 1;
            end else begin
              phase = P_LOAD; e_ready = 1;
            end
          end
          P_CLEAR: begin
            if (clear_left == 0) begin
              phase = P_LOAD; e_ready = 1;
            end else begin
              e_we = 1; e_addr = ADDR_W'(DEPTH - clear_left); e_wdata = '0;
              clear_left--;
            end
          end
          P_LOAD: if (in_valid) begin
            e_we = 1; e_addr = ADDR_W'(ld_next); e_wdata = in_data;
            e_count = e_count + 1'b1;
            if (in_last || ld_next == DEPTH - 1) begin
              phase = P_FINISH; e_ready = 0; e_done = 1; e_err = !in_last;
            end
            ld_next++;
          end
          default: begin
            phase = P_IDLE; e_hold = 0;
          end
        endcase
      end
    end
  end

  function automatic logic [63:0] pack(input logic rdy, we, hold, dn, er,
                                       input logic [ADDR_W:0] cnt,
                                       input logic [ADDR_W-1:0] ad,
                                       input logic [31:0] wd);
    return {6'b0, rdy, we, hold, dn, er, cnt,
            (we ? ad : {ADDR_W{1'b0}}), (we ? wd : 32'h0)};
  endfunction

  always @(negedge clk) begin
    if (m_live)
      check("outputs", pack(in_ready, mem_we, core_hold, done, error, word_count, mem_addr, mem_wdata),
            pack(e_ready, e_we, e_hold, e_done, e_err, e_count, e_addr, e_wdata));
  end

  // Stimulus helpers; all are entered and left at a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int g = 0; g < DEPTH + 16 && !ok; g++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    check("wait_ready_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int g = 0; g < DEPTH + 16 && !ok; g++) begin
      ok = (in_ready === 1'b1);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int w0, d0, z0;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, word_count, error}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

`ifdef INSN_LOADER_CLEAR_EN
    // Pre-filled memory must end up zero apart from the one loaded word.
    fill_req = 1'b1; @(negedge clk); fill_req = 1'b0;
    w0 = n_writes;
    pulse_start();
    send(32'h0000_0013, 1'b1);
    repeat (3) @(negedge clk);
    check("clr_mem0", 64'(ram[0]), 64'h13);
    begin
      int nz = 0;
      for (int i = 1; i < DEPTH; i++) if (ram[i] !== 32'h0) nz++;
      check("clr_nonzero_words", 64'(nz), 64'd0);
    end
    check("clr_write_count", 64'(n_writes - w0), 64'd1025);
`endif

    // Two-word program.
    w0 = n_writes; d0 = done_seen;
    pulse_start();
    send(32'h0320_8093, 1'b0);
    send(32'h0310_A113, 1'b1);
    repeat (3) @(negedge clk);
    check("basic_mem0", 64'(ram[0]), 64'h0320_8093);
    check("basic_mem1", 64'(ram[1]), 64'h0310_A113);
    check("basic_count", 64'(word_count), 64'd2);
    check("basic_error", 64'(error), 64'd0);
    check("basic_hold", 64'(core_hold), 64'd0);
    check("basic_done", 64'(done_seen - d0), 64'd1);
    check("basic_writes", 64'(n_writes - w0), 64'(CLR_W + 2));

    // in_valid toggling 1,0,1,0.
    w0 = n_writes;
    pulse_start();
    wait_ready();
    in_valid = 1'b1; in_data = 32'hA; in_last = 1'b0; @(negedge clk);
    in_valid = 1'b0; @(negedge clk);
    in_valid = 1'b1; in_data = 32'hB; in_last = 1'b1; @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; @(negedge clk);
    repeat (3) @(negedge clk);
    check("toggle_writes", 64'(n_writes - w0), 64'(CLR_W + 2));
    check("toggle_mem0", 64'(ram[0]), 64'hA);
    check("toggle_mem1", 64'(ram[1]), 64'hB);
    check("toggle_count", 64'(word_count), 64'd2);

    // start during LOAD is ignored.
    d0 = done_seen;
    pulse_start();
    wait_ready();
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    pulse_start();
    send(32'h33, 1'b1);
    repeat (3) @(negedge clk);
    check("restart_mem2", 64'(ram[2]), 64'h33);
    check("restart_last_addr", 64'(last_waddr), 64'd2);
    check("restart_count", 64'(word_count), 64'd3);
    check("restart_done", 64'(done_seen - d0), 64'd1);

    // Reset after three accepted words aborts; a new session starts at 0.
    pulse_start();
    wait_ready();
    send(32'h100, 1'b0);
    send(32'h101, 1'b0);
    send(32'h102, 1'b0);
    d0 = done_seen;
    reset = 1'b1;
    @(negedge clk);
    check("abort_outs", 64'({in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, word_count, error}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_no_done", 64'(done_seen - d0), 64'd0);
    check("abort_kept_mem2", 64'(ram[2]), 64'h102);
    pulse_start();
    wait_ready();
    send(32'h200, 1'b1);
    repeat (3) @(negedge clk);
    check("abort_new_mem0", 64'(ram[0]), 64'h200);
    check("abort_new_addr", 64'(last_waddr), 64'd0);
    check("abort_new_count", 64'(word_count), 64'd1);

    // Overflow: DEPTH words, never last.
    pulse_start();
    wait_ready();
    z0 = addr0_writes;
    for (int i = 0; i < DEPTH; i++) send(32'h1000 + 32'(i), 1'b0);
    repeat (3) @(negedge clk);
    check("ovf_error", 64'(error), 64'd1);
    check("ovf_count", 64'(word_count), 64'd1024);
    check("ovf_last_addr", 64'(last_waddr), 64'd1023);
    check("ovf_mem1023", 64'(ram[1023]), 64'h13FF);
    check("ovf_mem0", 64'(ram[0]), 64'h1000);
    check("ovf_addr0_writes", 64'(addr0_writes - z0), 64'd1);
    // Words offered in IDLE are not consumed; status holds.
    w0 = n_writes;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("idle_no_writes", 64'(n_writes - w0), 64'd0);
    check("idle_hold_error", 64'(error), 64'd1);
    check("idle_hold_count", 64'(word_count), 64'd1024);

    // Exactly full with last on the top word: no error.
    d0 = done_seen;
    pulse_start();
    wait_ready();
    for (int i = 0; i < DEPTH; i++) send(32'h5000 + 32'(i), (i == DEPTH - 1));
    repeat (3) @(negedge clk);
    check("full_error", 64'(error), 64'd0);
    check("full_count", 64'(word_count), 64'd1024);
    check("full_mem1023", 64'(ram[1023]), 64'h53FF);
    check("full_done", 64'(done_seen - d0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
